fetch_prefetch_unit: RTL
========================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_req_valid  out  1  fetch request valid.
REQ-008 SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port mem_req_addr  out  ADDR_W  fetch address.
REQ-010 SHALL have port mem_rsp_valid  in  1  in-order instruction return.
REQ-011 SHALL have port mem_rsp_data  in  DATA_W  returned instruction.
REQ-012 SHALL have port redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port redirect_pc  in  ADDR_W  redirect target.
REQ-014 SHALL have port inst_valid  out  1  queue head valid.
REQ-015 SHALL have port inst_ready  in  1  decode consumes head.
REQ-016 SHALL have ports inst_data (out, DATA_W), inst_pc (out, ADDR_W), inst_pc_next (out, ADDR_W): head instruction, its PC, PC+4.

Function
REQ-017 SHALL implement FSM S_BOOT -> S_RUN; S_BOOT lasts exactly one cycle after reset release with no request; S_RUN persists until reset.
REQ-018 SHALL drive mem_req_valid = S_RUN & !redirect_valid & (fifo_count + outstanding < DEPTH), independent of mem_req_ready; mem_req_addr = fetch_pc.
REQ-019 SHALL, on request handshake, increment fetch_pc by 4 modulo 2^ADDR_W and increment outstanding.
REQ-020 SHALL accept responses in request order, min latency 1 cycle; each response decrements outstanding; mem_rsp_valid with outstanding==0 ignored.
REQ-021 SHALL push {pc, data} into queue for non-discarded responses; pushed entry visible on inst_* the next cycle (no bypass).
REQ-022 SHALL pop head on inst_valid & inst_ready; simultaneous push and pop legal at any occupancy; overflow impossible by credit rule REQ-018.
REQ-023 SHALL, on redirect_valid: empty queue, ignore same-cycle pop and response push, set fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}, set discard_cnt = outstanding after this cycle's response decrement.
REQ-024 SHALL drop the next discard_cnt responses (decrementing it); requests to new path may issue from the cycle after redirect while discards pend.
REQ-025 SHALL keep inst_data/inst_pc stable while inst_valid & !inst_ready and no redirect.
REQ-026 SHALL compute inst_pc_next = inst_pc + 4 modulo 2^ADDR_W.

Reset
REQ-027 SHALL asynchronously set fetch_pc=RESET_PC, state=S_BOOT, queue empty, outstanding=0, discard_cnt=0.
REQ-028 SHALL hold mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, inst_pc_next=0 during reset; reset mid-operation abandons in-flight requests.

Structure
REQ-029 SHALL place state enum (S_BOOT, S_RUN) and INST_BYTES=4 in shared package fetch_pkg.
REQ-030 SHALL instantiate one sub-module fetch_fifo: synchronous flushable FIFO of {ADDR_W pc, DATA_W instr}, DEPTH entries, count output.
REQ-031 SHALL size outstanding and discard_cnt as $clog2(DEPTH+1) bits.

Verification
REQ-032 Reset release, mem_req_ready=1, 1-cycle memory -> first request cycle 2 at 0x0, then 0x4, 0x8; inst_pc 0x0 valid one cycle after first response.
REQ-033 inst_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC), then mem_req_valid=0; one pop -> one request at 0x10.
REQ-034 3 outstanding, redirect_pc=0x100 -> queue empty next cycle, next 3 responses dropped, first inst_pc=0x100.
REQ-035 redirect_pc=0x203 -> fetch address 0x200.
REQ-036 fetch_pc=0xFFFFFFFC -> next request 0x00000000; inst_pc_next of that entry = 0x0.
REQ-037 Assert reset with 2 outstanding and queue full -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch/prefetch block.
package fetch_pkg;

   typedef enum logic [0:0] {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } fetch_state_e;

   localparam int INST_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable prefetch queue holding {pc, instruction} entries; head is read combinationally.
module fetch_fifo #(
   parameter  int W     = 64,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Flush wins over both ports; a push into a full queue is only taken alongside a pop.
   assign do_pop    = pop && (count != '0) && !flush;
   assign do_push   = push && !flush && ((count != CW'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited requests, in-order returns, redirect flush.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] inst_pc_next
);

   localparam int                CW      = $clog2(DEPTH + 1);
   localparam int                EW      = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);
   localparam logic [CW:0]       CREDITS = (CW + 1)'(DEPTH);

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_post;
   logic [CW-1:0]     discard_cnt;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_used;
   logic              req_fire;
   logic              rsp_take;
   logic              push;
   logic              pop;
   logic [EW-1:0]     head;
   logic [ADDR_W-1:0] head_pc;

   assign redirect_aligned = redirect_pc & ~ADDR_W'(INST_BYTES - 1);
   // Queued entries plus in-flight requests can never exceed the queue size.
   assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_BOOT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mem_req_valid = 1'b0;
      case (state)
         S_BOOT:  state_nxt = S_RUN;
         S_RUN:   mem_req_valid = !redirect_valid && (credit_used < CREDITS);
         default: state_nxt = S_BOOT;
      endcase
   end

   assign mem_req_addr     = fetch_pc;
   assign req_fire         = mem_req_valid && mem_req_ready;
   assign rsp_take         = mem_rsp_valid && (outstanding != '0);
   assign push             = rsp_take && (discard_cnt == '0) && !redirect_valid;
   assign pop              = inst_valid && inst_ready && !redirect_valid;
   assign outstanding_post = outstanding - CW'(rsp_take);

   // rsp_pc tracks the PC of the next response that will actually be kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
      end else begin
         outstanding <= outstanding_post + CW'(req_fire);
         if (redirect_valid) begin
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            discard_cnt <= outstanding_post;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (push)     rsp_pc   <= rsp_pc + STEP;
            if (rsp_take && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({rsp_pc, mem_rsp_data}),
      .pop       (pop),
      .head_data (head),
      .count     (fifo_count)
   );

   assign head_pc      = head[EW-1:DATA_W];
   assign inst_valid   = (fifo_count != '0);
   assign inst_data    = inst_valid ? head[DATA_W-1:0] : '0;
   assign inst_pc      = inst_valid ? head_pc : '0;
   assign inst_pc_next = inst_valid ? head_pc + STEP : '0;

endmodule
